// File: rtl/rtc_bus_ctrl.sv
// Bus-cycle engine for the RTC multiplexed address/data bus.
// Runs one register access (address phase, gap, data phase) per request and pulses fin when done.
module rtc_bus_ctrl #(
  parameter int T_SU  = 2,
  parameter int T_PW  = 4,
  parameter int T_H   = 2,
  parameter int T_GAP = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       escritura,
  input  logic       lectura,
  input  logic [7:0] ADD2,
  input  logic [7:0] Dato_in,
  output logic       fin,
  output logic       busy,
  output logic [7:0] Dato_leido,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  input  logic [7:0] AD_in,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       A_D
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR_SU,
    ADDR_PW,
    ADDR_H,
    GAP,
    DATA_SU,
    DATA_PW,
    DATA_H,
    DONE,
    RECOVER
  } state_t;

  localparam logic [3:0] SU_M1  = 4'(T_SU - 1);
  localparam logic [3:0] PW_M1  = 4'(T_PW - 1);
  localparam logic [3:0] H_M1   = 4'(T_H - 1);
  localparam logic [3:0] GAP_M1 = 4'(T_GAP - 1);

  state_t     state, state_next;
  logic [3:0] count, count_next;
  logic [7:0] addr, addr_next;
  logic [7:0] wdata, wdata_next;
  logic       is_write, is_write_next;
  logic       capture;

  logic       fin_d, busy_d, ad_oe_d, cs_n_d, rd_n_d, wr_n_d, a_d_d;
  logic [7:0] ad_out_d;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= 4'd0;
      addr     <= 8'h00;
      wdata    <= 8'h00;
      is_write <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      addr     <= addr_next;
      wdata    <= wdata_next;
      is_write <= is_write_next;
    end
  end

  // Each phase counts down from (length - 1) and hands over to the next phase at zero.
  always_comb begin
    state_next    = state;
    count_next    = count;
    addr_next     = addr;
    wdata_next    = wdata;
    is_write_next = is_write;
    if (state == IDLE) begin
      if (escritura || lectura) begin
        state_next    = ADDR_SU;
        count_next    = SU_M1;
        addr_next     = ADD2;
        wdata_next    = Dato_in;
        is_write_next = escritura;
      end
    end else if (count != 4'd0) begin
      count_next = count - 4'd1;
    end else begin
      case (state)
        ADDR_SU: begin state_next = ADDR_PW; count_next = PW_M1;  end
        ADDR_PW: begin state_next = ADDR_H;  count_next = H_M1;   end
        ADDR_H:  begin state_next = GAP;     count_next = GAP_M1; end
        GAP:     begin state_next = DATA_SU; count_next = SU_M1;  end
        DATA_SU: begin state_next = DATA_PW; count_next = PW_M1;  end
        DATA_PW: begin state_next = DATA_H;  count_next = H_M1;   end
        DATA_H:  begin state_next = DONE;    count_next = 4'd0;   end
        DONE:    begin state_next = RECOVER; count_next = GAP_M1; end
        default: begin state_next = IDLE;    count_next = 4'd0;   end
      endcase
    end
  end

  assign capture = (state == DATA_PW) && (count == 4'd0) && !is_write;

  // Bus outputs are decoded from the upcoming state and registered so strobes never glitch.
  always_comb begin
    fin_d    = 1'b0;
    busy_d   = (state_next != IDLE);
    ad_oe_d  = 1'b0;
    ad_out_d = 8'h00;
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    a_d_d    = 1'b1;
    case (state_next)
      ADDR_SU, ADDR_PW, ADDR_H: begin
        cs_n_d   = 1'b0;
        a_d_d    = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_next;
        wr_n_d   = (state_next != ADDR_PW);
      end
      DATA_SU, DATA_PW, DATA_H: begin
        cs_n_d = 1'b0;
        if (is_write_next) begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_next;
          wr_n_d   = (state_next != DATA_PW);
        end else begin
          rd_n_d = (state_next != DATA_PW);
        end
      end
      DONE:    fin_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      fin        <= 1'b0;
      busy       <= 1'b0;
      AD_oe      <= 1'b0;
      AD_out     <= 8'h00;
      CS_n       <= 1'b1;
      RD_n       <= 1'b1;
      WR_n       <= 1'b1;
      A_D        <= 1'b1;
      Dato_leido <= 8'h00;
    end else begin
      fin    <= fin_d;
      busy   <= busy_d;
      AD_oe  <= ad_oe_d;
      AD_out <= ad_out_d;
      CS_n   <= cs_n_d;
      RD_n   <= rd_n_d;
      WR_n   <= wr_n_d;
      A_D    <= a_d_d;
      if (capture) Dato_leido <= AD_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Self-checking bench for rtc_bus_ctrl: a bus monitor rebuilds each transaction and
// compares it against a scoreboard of expected accesses, for default and fast timing.
module tb_rtc_bus_ctrl;

  localparam int D_SU = 2, D_PW = 4, D_H = 2, D_GAP = 2;
  localparam int F_SU = 1, F_PW = 1, F_H = 1, F_GAP = 2;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       exp_write;
    logic [7:0] exp_leido;
  } vec_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       is_write;
    logic [7:0] leido;
  } exp_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       reset, escritura, lectura, sel;
  logic [7:0] ADD2, Dato_in, cur_rdata, AD_in;
  int         rd_cnt = 0;

  logic       d_fin, d_busy, d_oe, d_cs, d_rd, d_wr, d_ad;
  logic [7:0] d_leido, d_out;
  logic       f_fin, f_busy, f_oe, f_cs, f_rd, f_wr, f_ad;
  logic [7:0] f_leido, f_out;
  logic       m_fin, m_busy, m_oe, m_cs, m_rd, m_wr, m_ad;
  logic [7:0] m_leido, m_out;
  int         su_now, pw_now, h_now, gap_now;

  assign m_fin   = sel ? f_fin   : d_fin;
  assign m_busy  = sel ? f_busy  : d_busy;
  assign m_oe    = sel ? f_oe    : d_oe;
  assign m_cs    = sel ? f_cs    : d_cs;
  assign m_rd    = sel ? f_rd    : d_rd;
  assign m_wr    = sel ? f_wr    : d_wr;
  assign m_ad    = sel ? f_ad    : d_ad;
  assign m_leido = sel ? f_leido : d_leido;
  assign m_out   = sel ? f_out   : d_out;
  assign su_now  = sel ? F_SU  : D_SU;
  assign pw_now  = sel ? F_PW  : D_PW;
  assign h_now   = sel ? F_H   : D_H;
  assign gap_now = sel ? F_GAP : D_GAP;

  // RTC model: read data only becomes valid after RD_n has been low for the full strobe width.
  assign AD_in = (rd_cnt == pw_now) ? cur_rdata : 8'hEE;
  always @(negedge CLK) begin
    if (!m_rd) rd_cnt <= rd_cnt + 1;
    else       rd_cnt <= 0;
  end

  rtc_bus_ctrl dut (
    .CLK(CLK), .reset(reset),
    .escritura(escritura & ~sel), .lectura(lectura & ~sel),
    .ADD2(ADD2), .Dato_in(Dato_in),
    .fin(d_fin), .busy(d_busy), .Dato_leido(d_leido),
    .AD_out(d_out), .AD_oe(d_oe), .AD_in(AD_in),
    .CS_n(d_cs), .RD_n(d_rd), .WR_n(d_wr), .A_D(d_ad)
  );

  rtc_bus_ctrl #(.T_SU(F_SU), .T_PW(F_PW), .T_H(F_H), .T_GAP(F_GAP)) dut_fast (
    .CLK(CLK), .reset(reset),
    .escritura(escritura & sel), .lectura(lectura & sel),
    .ADD2(ADD2), .Dato_in(Dato_in),
    .fin(f_fin), .busy(f_busy), .Dato_leido(f_leido),
    .AD_out(f_out), .AD_oe(f_oe), .AD_in(AD_in),
    .CS_n(f_cs), .RD_n(f_rd), .WR_n(f_wr), .A_D(f_ad)
  );

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  task automatic check_output(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out waiting, got no event, expected one", name);
  endtask

  // Bus monitor: per-transaction statistics, scored when fin is seen.
  int cyc = 0, start_cyc = 0, last_fin_cyc = 0, fin_count = 0, txn_count = 0;
  int addr_cyc, addr_wr_low, addr_bad, gap_cyc, data_cyc, data_wr_low, data_rd_low, data_oe, viol;
  logic [7:0] addr_seen, wr_val;
  logic prev_busy = 1'b0, prev_fin = 1'b0, in_txn = 1'b0;

  task automatic score();
    exp_t e;
    int   path;
    if (sb.size() == 0) begin
      report_timeout("scoreboard_empty");
      return;
    end
    e = sb.pop_front();
    path = su_now + pw_now + h_now;
    check_output("addr", addr_seen, e.addr);
    check_output("addr_cycles", addr_cyc, path);
    check_output("addr_wr_low", addr_wr_low, pw_now);
    check_output("addr_stable", addr_bad, 0);
    check_output("gap_cycles", gap_cyc, gap_now);
    check_output("latency", cyc - start_cyc, 2 * path + gap_now);
    if (e.is_write) begin
      check_output("data_wr_low", data_wr_low, pw_now);
      check_output("data_rd_low", data_rd_low, 0);
      check_output("wdata", wr_val, e.wdata);
      check_output("data_oe", data_oe, path);
    end else begin
      check_output("data_rd_low", data_rd_low, pw_now);
      check_output("data_wr_low", data_wr_low, 0);
      check_output("data_oe", data_oe, 0);
    end
    check_output("dato_leido", m_leido, e.leido);
    check_output("bus_rules", viol, 0);
  endtask

  always @(negedge CLK) begin
    if (!reset) begin
      in_txn    = 1'b0;
      prev_busy = 1'b0;
      prev_fin  = 1'b0;
    end else begin
      cyc++;
      if (m_busy && !prev_busy) begin
        start_cyc = cyc; txn_count++; in_txn = 1'b1;
        addr_cyc = 0; addr_wr_low = 0; addr_bad = 0; gap_cyc = 0; data_cyc = 0;
        data_wr_low = 0; data_rd_low = 0; data_oe = 0; viol = 0;
        addr_seen = 8'h00; wr_val = 8'h00;
      end
      if ((!m_rd && !m_wr) || (!m_rd && m_oe) || ((!m_rd || !m_wr) && m_cs)) viol++;
      if (in_txn) begin
        if (!m_cs && !m_ad) begin
          addr_cyc++;
          if (addr_cyc == 1) addr_seen = m_out;
          else if (m_out != addr_seen || !m_oe) addr_bad = 1;
          if (!m_wr) addr_wr_low++;
        end
        if (m_cs && !m_fin && addr_cyc > 0 && data_cyc == 0) gap_cyc++;
        if (!m_cs && m_ad) begin
          data_cyc++;
          if (!m_wr) begin data_wr_low++; wr_val = m_out; end
          if (!m_rd) data_rd_low++;
          if (m_oe) data_oe++;
        end
      end
      if (m_fin) begin
        if (prev_fin) report_timeout("fin_single_cycle");
        if (in_txn) score();
        in_txn = 1'b0;
        last_fin_cyc = cyc;
        fin_count++;
      end
      prev_busy = m_busy;
      prev_fin  = m_fin;
    end
  end

  logic [7:0] leido_model = 8'h00;

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (!m_busy) return;
    end
    report_timeout("wait_idle");
  endtask

  task automatic wait_fin(input int n);
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK); #1;
      if (fin_count > n) return;
    end
    report_timeout("wait_fin");
  endtask

  task automatic apply_stimulus(input vec_t v);
    int n;
    wait_idle();
    escritura = v.wr; lectura = v.rd; ADD2 = v.addr; Dato_in = v.wdata; cur_rdata = v.rdata;
    sb.push_back('{addr: v.addr, wdata: v.wdata, is_write: v.exp_write, leido: v.exp_leido});
    leido_model = v.exp_leido;
    n = fin_count;
    @(posedge CLK); #1;
    escritura = 1'b0; lectura = 1'b0; ADD2 = ~v.addr; Dato_in = ~v.wdata;
    wait_fin(n);
  endtask

  vec_t vecs[6];

  initial begin
    int n, rises, found;
    vecs[0] = '{wr: 1'b1, rd: 1'b0, addr: 8'h21, wdata: 8'h59, rdata: 8'h00, exp_write: 1'b1, exp_leido: 8'h00};
    vecs[1] = '{wr: 1'b0, rd: 1'b1, addr: 8'h33, wdata: 8'h00, rdata: 8'h7A, exp_write: 1'b0, exp_leido: 8'h7A};
    vecs[2] = '{wr: 1'b1, rd: 1'b1, addr: 8'h05, wdata: 8'hA5, rdata: 8'h3C, exp_write: 1'b1, exp_leido: 8'h7A};
    vecs[3] = '{wr: 1'b0, rd: 1'b1, addr: 8'h7F, wdata: 8'h00, rdata: 8'hC3, exp_write: 1'b0, exp_leido: 8'hC3};
    vecs[4] = '{wr: 1'b1, rd: 1'b0, addr: 8'h80, wdata: 8'hFF, rdata: 8'h00, exp_write: 1'b1, exp_leido: 8'hC3};
    vecs[5] = '{wr: 1'b0, rd: 1'b1, addr: 8'h01, wdata: 8'h00, rdata: 8'h5A, exp_write: 1'b0, exp_leido: 8'h5A};

    reset = 1'b0; escritura = 1'b0; lectura = 1'b0; sel = 1'b0;
    ADD2 = 8'h00; Dato_in = 8'h00; cur_rdata = 8'h00;
    repeat (3) @(negedge CLK);
    check_output("rst_cs_n", d_cs, 1);
    check_output("rst_rd_n", d_rd, 1);
    check_output("rst_wr_n", d_wr, 1);
    check_output("rst_a_d", d_ad, 1);
    check_output("rst_ad_oe", d_oe, 0);
    check_output("rst_ad_out", d_out, 0);
    check_output("rst_fin", d_fin, 0);
    check_output("rst_busy", d_busy, 0);
    check_output("rst_leido", d_leido, 0);
    reset = 1'b1;

    // Reset asserted in the middle of a write strobe must drop the bus immediately.
    @(negedge CLK);
    escritura = 1'b1; ADD2 = 8'h44; Dato_in = 8'h99;
    @(posedge CLK); #1;
    escritura = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge CLK);
      if (!d_wr && d_ad) found = 1;
    end
    if (found == 0) report_timeout("reach_data_pw");
    reset = 1'b0;
    #1;
    check_output("midrst_cs_n", d_cs, 1);
    check_output("midrst_wr_n", d_wr, 1);
    check_output("midrst_ad_oe", d_oe, 0);
    check_output("midrst_busy", d_busy, 0);
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    repeat (5) @(negedge CLK);
    check_output("post_rst_busy", d_busy, 0);
    check_output("post_rst_cs_n", d_cs, 1);

    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);

    // Held write request: address refreshed one cycle after fin, second access uses it.
    wait_idle();
    escritura = 1'b1; ADD2 = 8'h21; Dato_in = 8'h11;
    sb.push_back('{addr: 8'h21, wdata: 8'h11, is_write: 1'b1, leido: leido_model});
    sb.push_back('{addr: 8'h22, wdata: 8'h12, is_write: 1'b1, leido: leido_model});
    n = fin_count;
    rises = txn_count;
    wait_fin(n);
    @(negedge CLK);
    ADD2 = 8'h22; Dato_in = 8'h12;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge CLK); #1;
      if (txn_count > rises + 1) found = 1;
    end
    if (found == 0) report_timeout("held_accept");
    // fin is sampled one edge after its cycle; the accept edge comes T_GAP+1 edges after that.
    check_output("held_accept_gap", start_cyc - last_fin_cyc, D_GAP + 2);
    escritura = 1'b0;
    wait_fin(n + 1);
    repeat (30) @(negedge CLK);
    check_output("held_txn_count", txn_count, rises + 2);

    wait_idle();
    sel = 1'b1;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);

    repeat (10) @(negedge CLK);
    check_output("sb_leftover", sb.size(), 0);
    check_output("fin_total", fin_count, 14);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    report_timeout("watchdog");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
